// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the processor pipeline registers.
//   exe_mem_bus_t     : canonical EX->MEM payload layout (MSB first:
//                       regWrite, memToReg, memWrite, aluOut, writeData, writeReg)
//   DATA_W_DEF        : default datapath width
//   REG_ADDR_W_DEF    : default register-index width
//   exe_mem_bus_width : flattened bus width for any DATA_W / REG_ADDR_W,
//                       so parametrised stages keep the same field order as
//                       the struct even when widths differ from the defaults.
package cpu_pipe_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int REG_ADDR_W_DEF = 5;

  typedef struct packed {
    logic                      regWrite;
    logic                      memToReg;
    logic                      memWrite;
    logic [DATA_W_DEF-1:0]     aluOut;
    logic [DATA_W_DEF-1:0]     writeData;
    logic [REG_ADDR_W_DEF-1:0] writeReg;
  } exe_mem_bus_t;

  localparam int EXE_MEM_BUS_W = $bits(exe_mem_bus_t);

  // Three control bits, two data words and the destination index.
  function automatic int exe_mem_bus_width(input int data_w, input int reg_addr_w);
    return 3 + 2 * data_w + reg_addr_w;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic two-entry elastic register (output register + skid register).
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   i_valid / o_ready   : upstream handshake; o_ready comes straight from a
//                         flop so there is no combinational path from i_ready
//   i_flush             : drop everything held and any same-cycle input
//   i_data [W]          : upstream payload
//   o_valid / i_ready   : downstream handshake
//   o_data [W]          : downstream payload, stable while o_valid & !i_ready
module pipe_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic         i_flush,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  logic         r_out_valid;
  logic [W-1:0] r_out_data;
  logic         r_skid_valid;
  logic [W-1:0] r_skid_data;

  logic w_in_hs;
  logic w_out_free;

  // Upstream may only push while the skid slot is empty; whatever gets in
  // therefore always has somewhere to land (output or skid).
  assign o_ready    = !r_skid_valid;
  assign w_in_hs    = i_valid && !r_skid_valid;
  // Output register can take a new word if empty or being drained this edge.
  assign w_out_free = !r_out_valid || i_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
    end else if (i_flush) begin
      // Data flops keep stale contents; only the valid bits matter.
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_out_free) begin
      if (r_skid_valid) begin
        // Older word in the skid goes first. No input can arrive in this
        // cycle because o_ready was low.
        r_out_data   <= r_skid_data;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else if (w_in_hs) begin
        r_out_data  <= i_data;
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_in_hs) begin
      // Output stalled: park the new word in the skid.
      r_skid_data  <= i_data;
      r_skid_valid <= 1'b1;
    end
  end

  assign o_valid = r_out_valid;
  assign o_data  = r_out_data;

endmodule

// File: rtl/exe_mem_pipe_stage.sv
// Elastic EX->MEM pipeline stage.
// Ports:
//   clk, rst_n                         : clock, asynchronous active-low reset
//   inValid / inReady                  : handshake with the execute stage
//   flush                              : kill every held instruction
//   regWriteE, memToRegE, memWriteE    : execute-stage controls
//   ALUOut, writeDataE, writeRegE      : execute-stage data / destination
//   outValid / outReady                : handshake with the memory stage
//   regWriteM, memToRegM, memWriteM    : registered controls, forced 0 when
//                                        outValid is low
//   ALUOutM, writeDataM, writeRegM     : registered data / destination
// SKID_EN=1 uses a two-entry skid buffer (registered inReady, full
// throughput under backpressure). SKID_EN=0 is a single register whose
// inReady is !outValid | outReady.
module exe_mem_pipe_stage
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter bit SKID_EN    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic                  flush,
  input  logic                  regWriteE,
  input  logic                  memToRegE,
  input  logic                  memWriteE,
  input  logic [DATA_W-1:0]     ALUOut,
  input  logic [DATA_W-1:0]     writeDataE,
  input  logic [REG_ADDR_W-1:0] writeRegE,
  output logic                  outValid,
  input  logic                  outReady,
  output logic                  regWriteM,
  output logic                  memToRegM,
  output logic                  memWriteM,
  output logic [DATA_W-1:0]     ALUOutM,
  output logic [DATA_W-1:0]     writeDataM,
  output logic [REG_ADDR_W-1:0] writeRegM
);

  localparam int BUS_W = exe_mem_bus_width(DATA_W, REG_ADDR_W);

  logic [BUS_W-1:0] w_in_bus;
  logic [BUS_W-1:0] w_out_bus;
  logic             w_out_valid;
  logic             w_in_ready;

  // Same field order as exe_mem_bus_t.
  assign w_in_bus = {regWriteE, memToRegE, memWriteE, ALUOut, writeDataE, writeRegE};

  generate
    if (SKID_EN) begin : g_skid
      pipe_skid_buf #(
        .W(BUS_W)
      ) u_skid (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_valid(inValid),
        .o_ready(w_in_ready),
        .i_flush(flush),
        .i_data (w_in_bus),
        .o_valid(w_out_valid),
        .i_ready(outReady),
        .o_data (w_out_bus)
      );
    end else begin : g_reg
      logic             r_valid;
      logic [BUS_W-1:0] r_data;

      // Free when empty or draining this edge; a full register with a
      // simultaneous in/out handshake is replaced without a bubble.
      assign w_in_ready = !r_valid || outReady;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_valid <= 1'b0;
          r_data  <= '0;
        end else if (flush) begin
          r_valid <= 1'b0;
        end else if (w_in_ready) begin
          r_valid <= inValid;
          if (inValid) begin
            r_data <= w_in_bus;
          end
        end
      end

      assign w_out_valid = r_valid;
      assign w_out_bus   = r_data;
    end
  endgenerate

  assign inReady  = w_in_ready;
  assign outValid = w_out_valid;

  // Controls are qualified by outValid so a stale or flushed entry can never
  // write the register file or memory; data fields need no gating.
  assign regWriteM  = w_out_bus[BUS_W-1] && w_out_valid;
  assign memToRegM  = w_out_bus[BUS_W-2] && w_out_valid;
  assign memWriteM  = w_out_bus[BUS_W-3] && w_out_valid;
  assign ALUOutM    = w_out_bus[2*DATA_W+REG_ADDR_W-1 -: DATA_W];
  assign writeDataM = w_out_bus[DATA_W+REG_ADDR_W-1 -: DATA_W];
  assign writeRegM  = w_out_bus[REG_ADDR_W-1:0];

endmodule

// File: tb/tb_exe_mem_pipe_stage.sv
// Directed and randomised checks of exe_mem_pipe_stage, instance 0 with the
// skid buffer and instance 1 with the single register.
module tb_exe_mem_pipe_stage;
  import cpu_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid [2];
  logic        in_ready [2];
  logic        flush    [2];
  logic        rw_e     [2];
  logic        mtr_e    [2];
  logic        mw_e     [2];
  logic [31:0] alu_e    [2];
  logic [31:0] wd_e     [2];
  logic [4:0]  wr_e     [2];
  logic        out_valid[2];
  logic        out_ready[2];
  logic        rw_m     [2];
  logic        mtr_m    [2];
  logic        mw_m     [2];
  logic [31:0] alu_m    [2];
  logic [31:0] wd_m     [2];
  logic [4:0]  wr_m     [2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  exe_mem_pipe_stage #(.DATA_W(32), .REG_ADDR_W(5), .SKID_EN(1'b1)) dut_skid (
    .clk(clk), .rst_n(rst_n), .inValid(in_valid[0]), .inReady(in_ready[0]),
    .flush(flush[0]), .regWriteE(rw_e[0]), .memToRegE(mtr_e[0]), .memWriteE(mw_e[0]),
    .ALUOut(alu_e[0]), .writeDataE(wd_e[0]), .writeRegE(wr_e[0]),
    .outValid(out_valid[0]), .outReady(out_ready[0]), .regWriteM(rw_m[0]),
    .memToRegM(mtr_m[0]), .memWriteM(mw_m[0]), .ALUOutM(alu_m[0]),
    .writeDataM(wd_m[0]), .writeRegM(wr_m[0])
  );

  exe_mem_pipe_stage #(.DATA_W(32), .REG_ADDR_W(5), .SKID_EN(1'b0)) dut_reg (
    .clk(clk), .rst_n(rst_n), .inValid(in_valid[1]), .inReady(in_ready[1]),
    .flush(flush[1]), .regWriteE(rw_e[1]), .memToRegE(mtr_e[1]), .memWriteE(mw_e[1]),
    .ALUOut(alu_e[1]), .writeDataE(wd_e[1]), .writeRegE(wr_e[1]),
    .outValid(out_valid[1]), .outReady(out_ready[1]), .regWriteM(rw_m[1]),
    .memToRegM(mtr_m[1]), .memWriteM(mw_m[1]), .ALUOutM(alu_m[1]),
    .writeDataM(wd_m[1]), .writeRegM(wr_m[1])
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exe_mem_bus_t mk(input logic rw, input logic mtr, input logic mw,
                                      input logic [31:0] a, input logic [31:0] w,
                                      input logic [4:0] r);
    exe_mem_bus_t b;
    b.regWrite = rw; b.memToReg = mtr; b.memWrite = mw;
    b.aluOut = a; b.writeData = w; b.writeReg = r;
    return b;
  endfunction

  function automatic exe_mem_bus_t obs_bus(input int d);
    return mk(rw_m[d], mtr_m[d], mw_m[d], alu_m[d], wd_m[d], wr_m[d]);
  endfunction

  task automatic drive(input int d, input logic v, input exe_mem_bus_t b);
    in_valid[d] = v;
    rw_e[d] = b.regWrite; mtr_e[d] = b.memToReg; mw_e[d] = b.memWrite;
    alu_e[d] = b.aluOut; wd_e[d] = b.writeData; wr_e[d] = b.writeReg;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  exe_mem_bus_t item;
  exe_mem_bus_t it_a, it_b, it_c;
  exe_mem_bus_t sb_q [2][$];
  exe_mem_bus_t prev_obs [2];
  logic         prev_stall [2];

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      drive(d, 1'b0, mk(0, 0, 0, 0, 0, 0));
      flush[d] = 1'b0;
      out_ready[d] = 1'b0;
    end
    repeat (3) step();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_valid%0d", d), 128'(out_valid[d]), 128'(0));
      check($sformatf("rst_bus%0d", d), 128'(obs_bus(d)), 128'(0));
    end
    #2 rst_n = 1'b1;
    step();

    // Asynchronous reset mid-cycle while holding an instruction.
    item = mk(1, 1, 1, 32'hDEAD, 32'hBEEF, 5'd7);
    drive(0, 1'b1, item);
    step();
    check("pre_rst_valid", 128'(out_valid[0]), 128'(1));
    check("pre_rst_bus", 128'(obs_bus(0)), 128'(item));
    drive(0, 1'b0, mk(0, 0, 0, 0, 0, 0));
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 128'(out_valid[0]), 128'(0));
    check("async_rst_bus", 128'(obs_bus(0)), 128'(0));
    #1 rst_n = 1'b1;
    step();
    check("post_rst_ready", 128'(in_ready[0]), 128'(1));

    // Streaming, 8 back-to-back with outReady high.
    out_ready[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      item = mk(1'b1, i[1], i[0], 32'h10 + 32'(i), 32'hA000 + 32'(i), 5'(i + 1));
      drive(0, 1'b1, item);
      #1 check($sformatf("stream_ready%0d", i), 128'(in_ready[0]), 128'(1));
      step();
      check($sformatf("stream_valid%0d", i), 128'(out_valid[0]), 128'(1));
      check($sformatf("stream_bus%0d", i), 128'(obs_bus(0)), 128'(item));
    end
    drive(0, 1'b0, mk(1, 1, 1, 0, 0, 0));
    step();
    check("stream_drain_valid", 128'(out_valid[0]), 128'(0));
    check("bubble_rw", 128'({rw_m[0], mtr_m[0], mw_m[0]}), 128'(0));

    // Backpressure into the skid.
    it_a = mk(1, 0, 0, 32'h10, 32'h1, 5'd1);
    it_b = mk(0, 1, 0, 32'h11, 32'h2, 5'd2);
    it_c = mk(0, 0, 1, 32'h12, 32'h3, 5'd3);
    out_ready[0] = 1'b0;
    drive(0, 1'b1, it_a);
    step();
    check("bp1_bus", 128'(obs_bus(0)), 128'(it_a));
    check("bp1_ready", 128'(in_ready[0]), 128'(1));
    drive(0, 1'b1, it_b);
    step();
    check("bp2_bus", 128'(obs_bus(0)), 128'(it_a));
    check("bp2_ready", 128'(in_ready[0]), 128'(0));
    drive(0, 1'b1, it_c);
    step();
    check("bp3_bus_stable", 128'(obs_bus(0)), 128'(it_a));
    check("bp3_ready", 128'(in_ready[0]), 128'(0));
    out_ready[0] = 1'b1;
    step();
    check("bp_rel1_bus", 128'(obs_bus(0)), 128'(it_b));
    check("bp_rel1_ready", 128'(in_ready[0]), 128'(1));
    step();
    check("bp_rel2_bus", 128'(obs_bus(0)), 128'(it_c));
    drive(0, 1'b0, mk(0, 0, 0, 0, 0, 0));
    step();
    check("bp_empty", 128'(out_valid[0]), 128'(0));

    // Flush with output and skid full.
    out_ready[0] = 1'b0;
    drive(0, 1'b1, mk(1, 0, 1, 32'h20, 32'h0, 5'd4));
    step();
    drive(0, 1'b1, mk(1, 0, 1, 32'h21, 32'h0, 5'd5));
    step();
    check("fl_full_ready", 128'(in_ready[0]), 128'(0));
    drive(0, 1'b1, mk(1, 0, 1, 32'h22, 32'h0, 5'd6));
    flush[0] = 1'b1;
    step();
    check("fl_valid", 128'(out_valid[0]), 128'(0));
    check("fl_ctrl", 128'({rw_m[0], mw_m[0], mtr_m[0]}), 128'(0));
    check("fl_ready", 128'(in_ready[0]), 128'(1));
    // Flush while a handshake is accepted: the input must vanish.
    drive(0, 1'b1, mk(1, 1, 1, 32'h23, 32'h0, 5'd7));
    step();
    flush[0] = 1'b0;
    out_ready[0] = 1'b1;
    drive(0, 1'b0, mk(1, 1, 1, 0, 0, 0));
    check("fl_hs_drop1", 128'(out_valid[0]), 128'(0));
    step();
    check("fl_hs_drop2", 128'(out_valid[0]), 128'(0));
    check("bubble_gate", 128'({rw_m[0], mw_m[0]}), 128'(0));

    // Single-register variant.
    it_a = mk(1, 1, 0, 32'h30, 32'h5, 5'd9);
    it_b = mk(0, 1, 1, 32'h31, 32'h6, 5'd10);
    out_ready[1] = 1'b0;
    drive(1, 1'b1, it_a);
    #1 check("r_empty_ready", 128'(in_ready[1]), 128'(1));
    step();
    check("r_load", 128'(obs_bus(1)), 128'(it_a));
    drive(1, 1'b1, it_b);
    #1 check("r_full_ready", 128'(in_ready[1]), 128'(0));
    step();
    check("r_stall_bus", 128'(obs_bus(1)), 128'(it_a));
    out_ready[1] = 1'b1;
    #1 check("r_comb_ready", 128'(in_ready[1]), 128'(1));
    step();
    check("r_replace", 128'(obs_bus(1)), 128'(it_b));
    check("r_replace_valid", 128'(out_valid[1]), 128'(1));
    drive(1, 1'b1, mk(1, 1, 1, 32'h32, 32'h7, 5'd11));
    flush[1] = 1'b1;
    step();
    flush[1] = 1'b0;
    drive(1, 1'b0, mk(0, 0, 0, 0, 0, 0));
    check("r_flush_valid", 128'(out_valid[1]), 128'(0));
    check("r_flush_ctrl", 128'({rw_m[1], mtr_m[1], mw_m[1]}), 128'(0));

    // Randomised traffic on both instances with a scoreboard.
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    step();
    for (int d = 0; d < 2; d++) begin
      prev_stall[d] = 1'b0;
      prev_obs[d] = '0;
      sb_q[d].delete();
    end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int d = 0; d < 2; d++) begin
        item = mk(1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom));
        drive(d, ($urandom_range(0, 9) < 7), item);
        out_ready[d] = ($urandom_range(0, 9) < 6);
        flush[d] = ($urandom_range(0, 15) == 0);
      end
      #1;
      for (int d = 0; d < 2; d++) begin
        exe_mem_bus_t o;
        o = obs_bus(d);
        if (!out_valid[d])
          check("rnd_gate", 128'({rw_m[d], mtr_m[d], mw_m[d]}), 128'(0));
        if (prev_stall[d]) begin
          check("rnd_stable_valid", 128'(out_valid[d]), 128'(1));
          check("rnd_stable_bus", 128'(o), 128'(prev_obs[d]));
        end
        check($sformatf("rnd_occ%0d", d), 128'(out_valid[d]), 128'(sb_q[d].size() > 0));
        if (out_valid[d] && out_ready[d]) begin
          if (sb_q[d].size() == 0) check("rnd_sb_empty", 128'(1), 128'(0));
          else check($sformatf("rnd_order%0d", d), 128'(o), 128'(sb_q[d].pop_front()));
        end
        if (flush[d]) sb_q[d].delete();
        else if (in_valid[d] && in_ready[d]) sb_q[d].push_back(item_of(d));
        if (sb_q[d].size() > (d == 0 ? 2 : 1))
          check($sformatf("rnd_depth%0d", d), 128'(sb_q[d].size()), 128'(d == 0 ? 2 : 1));
        prev_stall[d] = out_valid[d] && !out_ready[d] && !flush[d];
        prev_obs[d] = o;
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  function automatic exe_mem_bus_t item_of(input int d);
    return mk(rw_e[d], mtr_e[d], mw_e[d], alu_e[d], wd_e[d], wr_e[d]);
  endfunction

endmodule
